// File: rtl/soc_system_prng_ctrl_if.sv
// CSR (Avalon-MM slave) and random-word stream signals of the PRNG sequencer.
// The slave modport is the PRNG side; the master modport is the HPS/downstream side.
interface soc_system_prng_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] rnd_data;
  logic        rnd_valid;
  logic        rnd_ready;

  modport slave (
    input  address, chipselect, write_n, writedata, rnd_ready,
    output readdata, rnd_data, rnd_valid
  );

  modport master (
    output address, chipselect, write_n, writedata, rnd_ready,
    input  readdata, rnd_data, rnd_valid
  );
endinterface

// File: rtl/soc_system_prng_ctrl.sv
// Seed-PIO sequencer: loads a Galois LFSR and streams COUNT words over valid/ready.
// Optional feature macro PRNG_CTRL_IRQ_EN adds the level done interrupt and CTRL irq_enable bit.
module soc_system_prng_ctrl #(
  parameter logic [31:0] LFSR_TAPS = 32'h80200003,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [31:0]          seed_in,
  output logic                 busy,
  soc_system_prng_ctrl_if.slave bus
`ifdef PRNG_CTRL_IRQ_EN
  ,
  output logic                 irq
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t             state, state_next;
  logic [31:0]        lfsr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   remaining;
  logic [CNT_W-1:0]   produced;
  logic               done;
  logic               aborted;
  logic               wr;
  logic               start;
  logic               abort;
  logic               xfer;
  logic               unused_wdata;

  assign wr    = bus.chipselect & ~bus.write_n;
  // Abort takes priority when both bits arrive in the same CTRL write.
  assign abort = wr && (bus.address == 2'd0) && bus.writedata[1];
  assign start = wr && (bus.address == 2'd0) && bus.writedata[0] && !bus.writedata[1];

  assign busy          = (state == S_LOAD) || (state == S_RUN);
  assign bus.rnd_valid = (state == S_RUN);
  assign bus.rnd_data  = lfsr;
  assign xfer          = bus.rnd_valid & bus.rnd_ready;
  assign unused_wdata  = ^bus.writedata;

`ifdef PRNG_CTRL_IRQ_EN
  logic irq_en;
  assign irq = done & irq_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      irq_en <= 1'b0;
    else if (wr && (bus.address == 2'd0))
      irq_en <= bus.writedata[2];
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = (count != '0) ? S_LOAD : S_DONE;
      S_LOAD: state_next = abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (abort)
          state_next = S_IDLE;
        else if (xfer && (remaining == CNT_W'(1)))
          state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr      <= '0;
      count     <= '0;
      remaining <= '0;
      produced  <= '0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      if (wr && (bus.address == 2'd1) && !busy)
        count <= bus.writedata[CNT_W-1:0];
      if (wr && (bus.address == 2'd2)) begin
        if (bus.writedata[1]) done    <= 1'b0;
        if (bus.writedata[2]) aborted <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            done     <= 1'b0;
            aborted  <= 1'b0;
            produced <= '0;
          end
        end
        S_LOAD: begin
          lfsr      <= (seed_in == '0) ? 32'h1 : seed_in;
          remaining <= count;
          if (abort) aborted <= 1'b1;
        end
        S_RUN: begin
          if (xfer) begin
            lfsr      <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : '0);
            remaining <= remaining - 1'b1;
            if (produced != '1) produced <= produced + 1'b1;
          end
          if (abort) aborted <= 1'b1;
        end
        S_DONE: done <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
`ifdef PRNG_CTRL_IRQ_EN
      2'd0: bus.readdata = {29'd0, irq_en, 2'b00};
`else
      2'd0: bus.readdata = '0;
`endif
      2'd1: bus.readdata = 32'(count);
      2'd2: bus.readdata = {29'd0, aborted, done, busy};
      2'd3: bus.readdata = 32'(produced);
      default: bus.readdata = '0;
    endcase
  end

endmodule
